// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: pushes two WIDTH-bit operands LSB-first through one
// full-adder cell (two half adders) under a start/busy/done handshake.
module serial_add_ctrl #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sr_reg, a_sr_next;
  logic [WIDTH-1:0] b_sr_reg, b_sr_next;
  logic [WIDTH-1:0] res_sr_reg, res_sr_next;
  logic             carry_reg, carry_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic             cout_reg, cout_next;

  // Full-adder cell as two half adders: (a,b) then (partial sum, carry).
  logic ha0_s, ha0_c, ha1_s, ha1_c;
  logic fa_sum, fa_carry;

  assign ha0_s    = a_sr_reg[0] ^ b_sr_reg[0];
  assign ha0_c    = a_sr_reg[0] & b_sr_reg[0];
  assign ha1_s    = ha0_s ^ carry_reg;
  assign ha1_c    = ha0_s & carry_reg;
  assign fa_sum   = ha1_s;
  assign fa_carry = ha0_c | ha1_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      a_sr_reg   <= '0;
      b_sr_reg   <= '0;
      res_sr_reg <= '0;
      carry_reg  <= 1'b0;
      count_reg  <= '0;
      sum_reg    <= '0;
      cout_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      a_sr_reg   <= a_sr_next;
      b_sr_reg   <= b_sr_next;
      res_sr_reg <= res_sr_next;
      carry_reg  <= carry_next;
      count_reg  <= count_next;
      sum_reg    <= sum_next;
      cout_reg   <= cout_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    a_sr_next   = a_sr_reg;
    b_sr_next   = b_sr_reg;
    res_sr_next = res_sr_reg;
    carry_next  = carry_reg;
    count_next  = count_reg;
    sum_next    = sum_reg;
    cout_next   = cout_reg;

    if (ena) begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            a_sr_next  = a;
            b_sr_next  = b;
            carry_next = cin;
            count_next = '0;
            state_next = RUN;
          end else begin
            state_next = IDLE;
          end
        end
        RUN: begin
          a_sr_next   = a_sr_reg >> 1;
          b_sr_next   = b_sr_reg >> 1;
          res_sr_next = {fa_sum, res_sr_reg[WIDTH-1:1]};
          carry_next  = fa_carry;
          count_next  = count_reg + CW'(1);
          // Last bit: publish the whole word at once so sum never shows partials.
          if (count_reg == CW'(WIDTH - 1)) begin
            count_next = '0;
            sum_next   = {fa_sum, res_sr_reg[WIDTH-1:1]};
            cout_next  = fa_carry;
            state_next = DONE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);
  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed cases plus random operations
// compared against plain a+b+cin arithmetic.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ena = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int           n_checks = 0;
  int           n_bad = 0;
  logic [W-1:0] last_sum = '0;
  logic         last_cout = 1'b0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
    .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts one operation from IDLE or DONE and walks it to DONE.
  // stall_at/junk_at name the RUN cycle (0..W-1) for an ena stall or a stray start; -1 = none.
  task automatic do_op(input logic [W-1:0] a_v, input logic [W-1:0] b_v, input logic cin_v,
                       input int stall_at, input int stall_len, input int junk_at);
    logic [W:0] exp;
    exp = {1'b0, a_v} + {1'b0, b_v} + {{W{1'b0}}, cin_v};
    ena = 1'b1; start = 1'b1; a = a_v; b = b_v; cin = cin_v;
    tick();
    start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    for (int i = 0; i < W; i++) begin
      check("run_busy", 32'(busy), 32'd1);
      check("run_done", 32'(done), 32'd0);
      check("run_sum_hold", 32'(sum), 32'(last_sum));
      check("run_cout_hold", 32'(cout), 32'(last_cout));
      if (i == junk_at) begin
        start = 1'b1; a = W'($urandom); b = W'($urandom);
      end else begin
        start = 1'b0;
      end
      if (i == stall_at) begin
        ena = 1'b0;
        for (int k = 0; k < stall_len; k++) begin
          tick();
          check("stall_busy", 32'(busy), 32'd1);
          check("stall_done", 32'(done), 32'd0);
          check("stall_sum", 32'(sum), 32'(last_sum));
        end
        ena = 1'b1;
      end
      tick();
    end
    start = 1'b0;
    check("end_done", 32'(done), 32'd1);
    check("end_busy", 32'(busy), 32'd0);
    check("end_sum", 32'(sum), 32'(exp[W-1:0]));
    check("end_cout", 32'(cout), 32'(exp[W]));
    $display("op %02h + %02h + %0d -> sum=%02h cout=%0d (exp %02h %0d)",
             a_v, b_v, cin_v, sum, cout, exp[W-1:0], exp[W]);
    last_sum  = exp[W-1:0];
    last_cout = exp[W];
  endtask

  task automatic go_idle();
    start = 1'b0; ena = 1'b1;
    tick();
    check("idle_done", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_sum", 32'(sum), 32'(last_sum));
  endtask

  initial begin
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_busy", 32'(busy), 32'd0);

    // Basic add
    do_op(8'h3C, 8'h05, 1'b0, -1, 0, -1);
    go_idle();
    // Carry chain
    do_op(8'hFF, 8'h01, 1'b0, -1, 0, -1);
    go_idle();
    do_op(8'hFF, 8'h00, 1'b1, -1, 0, -1);
    go_idle();
    // Stray start during RUN
    do_op(8'h10, 8'h20, 1'b0, -1, 0, 3);
    go_idle();
    // ena stall mid-RUN
    do_op(8'h5A, 8'h33, 1'b1, 4, 5, -1);
    // DONE frozen while ena=0
    ena = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("done_frozen", 32'(done), 32'd1);
    end
    go_idle();
    // Back-to-back: start held during DONE
    do_op(8'h12, 8'h34, 1'b0, -1, 0, -1);
    do_op(8'h80, 8'h80, 1'b0, -1, 0, -1);
    go_idle();

    // Async reset mid-RUN
    ena = 1'b1; start = 1'b1; a = 8'h77; b = 8'h66; cin = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("pre_arst_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_sum", 32'(sum), 32'd0);
    check("arst_cout", 32'(cout), 32'd0);
    tick();
    #2 rst_n = 1'b1;
    tick();
    check("arst_idle_busy", 32'(busy), 32'd0);
    check("arst_idle_done", 32'(done), 32'd0);
    last_sum = '0; last_cout = 1'b0;
    do_op(8'h01, 8'h01, 1'b0, -1, 0, -1);

    // Random operations
    for (int n = 0; n < 30; n++) begin
      int st, jk;
      st = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, W - 1)) : -1;
      jk = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, W - 1)) : -1;
      do_op(W'($urandom), W'($urandom), 1'($urandom), st, int'($urandom_range(1, 4)), jk);
      if ($urandom_range(0, 1) == 1) go_idle();
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
